// File: rtl/npc_pkg.sv
// Shared encodings, BTB entry layout and small helpers for the next-PC unit.
package npc_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned WORD_W = 30;
    localparam int unsigned CTR_W  = 2;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_BR   = 2'b01,
        KIND_J    = 2'b10,
        KIND_JR   = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'b000,
        CMP_BNE  = 3'b001,
        CMP_BGEZ = 3'b100,
        CMP_BGTZ = 3'b101,
        CMP_BLEZ = 3'b110,
        CMP_BLTZ = 3'b111
    } cmp_e;

    localparam logic [CTR_W-1:0] CTR_ALLOC_BR = 2'b10;
    localparam logic [CTR_W-1:0] CTR_STRONG   = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MAX      = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MIN      = 2'b00;

    // Tag holds the word address above the index bits, zero-extended to 30 bits.
    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] tag;
        logic [WORD_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    function automatic logic [WORD_W-1:0] tag_of(input logic [WORD_W-1:0] word,
                                                 input int unsigned        idx_w);
        return word >> idx_w;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                  input logic             up);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != CTR_MAX) res = CTR_W'(ctr + CTR_W'(1));
        end else begin
            if (ctr != CTR_MIN) res = CTR_W'(ctr - CTR_W'(1));
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; undefined opcodes resolve not-taken.
module branch_cmp
    import npc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  cmpop,
    output logic        taken
);

    logic a_zero;
    logic a_neg;

    always_comb begin
        a_zero = (a == 32'd0);
        a_neg  = a[31];
        taken  = 1'b0;
        case (cmpop)
            CMP_BEQ:  taken = (a == b);
            CMP_BNE:  taken = (a != b);
            CMP_BGEZ: taken = ~a_neg;
            CMP_BGTZ: taken = ~a_neg & ~a_zero;
            CMP_BLEZ: taken = a_neg | a_zero;
            CMP_BLTZ: taken = a_neg;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_npc.sv
// Next-PC unit: direct-mapped BTB with 2-bit counters, D-stage resolution and redirect.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
module branch_predict_npc
    import npc_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01
`ifdef BRANCH_STATS_EN
    ,
    parameter int unsigned STAT_W   = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    output logic [31:0] f_pred_pc,
    input  logic        d_valid,
    input  logic        d_stall,
    input  logic [31:0] d_pc4,
    input  logic [25:0] d_i26,
    input  logic [1:0]  d_kind,
    input  logic [2:0]  d_cmpop,
    input  logic [31:0] d_rs,
    input  logic [31:0] d_rt,
    input  logic [31:0] d_pred_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_miss
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [WORD_W-1:0] f_tag;
    btb_entry_t        f_ent;
    logic              f_hit;

    logic [WORD_W-1:0] d_word;
    logic [IDX_W-1:0]  d_idx;
    logic [WORD_W-1:0] d_tag;
    btb_entry_t        d_ent;
    logic              d_hit;
    logic              d_fire;

    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] d_target;
    logic        d_taken;
    logic        cmp_taken;
    logic [31:0] actual_pc;

    btb_entry_t new_ent;
    logic       wr_en;

    // Fetch lookup sees only pre-edge table contents.
    always_comb begin
        f_idx        = f_pc[IDX_W+1:2];
        f_tag        = tag_of(f_pc[31:2], IDX_W);
        f_ent        = btb_q[f_idx];
        f_hit        = f_ent.valid && (f_ent.tag == f_tag);
        f_pred_taken = f_hit && f_ent.ctr[1];
        f_pred_pc    = f_pred_taken ? {f_ent.target, 2'b00} : (f_pc + 32'd4);
    end

    branch_cmp u_cmp (
        .a     (d_rs),
        .b     (d_rt),
        .cmpop (d_cmpop),
        .taken (cmp_taken)
    );

    // D stage works on the instruction's own PC, recovered from PC+4.
    always_comb begin
        d_word    = d_pc4[31:2] - 30'd1;
        d_idx     = d_word[IDX_W-1:0];
        d_tag     = tag_of(d_word, IDX_W);
        d_ent     = btb_q[d_idx];
        d_hit     = d_ent.valid && (d_ent.tag == d_tag);
        d_fire    = d_valid & ~d_stall;
        br_target = d_pc4 + {{14{d_i26[15]}}, d_i26[15:0], 2'b00};
        j_target  = {d_pc4[31:28], d_i26, 2'b00};
    end

    always_comb begin
        d_taken  = 1'b0;
        d_target = d_pc4;
        case (d_kind)
            KIND_BR: begin
                d_taken  = cmp_taken;
                d_target = br_target;
            end
            KIND_J: begin
                d_taken  = 1'b1;
                d_target = j_target;
            end
            KIND_JR: begin
                d_taken  = 1'b1;
                d_target = d_rs;
            end
            default: begin
                d_taken  = 1'b0;
                d_target = d_pc4;
            end
        endcase
        actual_pc   = d_taken ? d_target : d_pc4;
        redirect    = d_fire & (actual_pc != d_pred_pc);
        redirect_pc = actual_pc;
    end

    // Training: one entry at the D index may be rewritten per resolved instruction.
    always_comb begin
        new_ent = d_ent;
        wr_en   = 1'b0;
        if (d_fire) begin
            case (d_kind)
                KIND_BR: begin
                    if (d_hit) begin
                        new_ent.ctr    = ctr_step(d_ent.ctr, cmp_taken);
                        new_ent.target = br_target[31:2];
                        wr_en          = 1'b1;
                    end else if (cmp_taken) begin
                        new_ent.valid  = 1'b1;
                        new_ent.tag    = d_tag;
                        new_ent.target = br_target[31:2];
                        new_ent.ctr    = CTR_ALLOC_BR;
                        wr_en          = 1'b1;
                    end
                end
                KIND_J, KIND_JR: begin
                    new_ent.valid  = 1'b1;
                    new_ent.tag    = d_tag;
                    new_ent.target = d_target[31:2];
                    new_ent.ctr    = CTR_STRONG;
                    wr_en          = 1'b1;
                end
                default: begin
                    if (d_hit) begin
                        new_ent.valid = 1'b0;
                        wr_en         = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        btb_d = btb_q;
        if (wr_en) btb_d[d_idx] = new_ent;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[IDX_W'(i)] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
            end
        end else begin
            btb_q <= btb_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_br_d;
    logic [STAT_W-1:0] stat_miss_q;
    logic [STAT_W-1:0] stat_miss_d;

    // Counters wrap naturally at 2^STAT_W.
    always_comb begin
        stat_br_d   = stat_br_q + STAT_W'(d_fire && (d_kind != KIND_NONE));
        stat_miss_d = stat_miss_q + STAT_W'(redirect);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_br   = stat_br_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule
